// File: rtl/rename_pkg.sv
// Shared helpers for the rename stage: index-width derivation, the reset
// architectural-to-physical mapping and the free-list search.
package rename_pkg;

    // Widest free bitmap the search function handles.
    localparam int MAX_PREGS = 256;

    function automatic int idx_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction

    function automatic int arch_w(input int arch_regs);
        return idx_w(arch_regs);
    endfunction

    function automatic int phys_w(input int phys_regs);
        return idx_w(phys_regs);
    endfunction

    // Out of reset, architectural register a lives in physical register a.
    function automatic int reset_map(input int areg);
        return areg;
    endfunction

    // Preg 0 is never free, so 0 doubles as the "nothing free" answer.
    function automatic int lowest_set(input logic [MAX_PREGS-1:0] bits);
        int idx;
        idx = 0;
        for (int i = MAX_PREGS - 1; i >= 0; i--)
            if (bits[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/rename_unit_if.sv
// Decode-side, dispatch-side and ROB-retire signals of the rename stage.
interface rename_unit_if
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int RETIRE_W  = 2
);
    localparam int AW = arch_w(ARCH_REGS);
    localparam int PW = phys_w(PHYS_REGS);

    logic                   in_valid;
    logic                   in_ready;
    logic [AW-1:0]          sr1;
    logic [AW-1:0]          sr2;
    logic [AW-1:0]          dr;
    logic                   dr_we;
    logic                   has_imm;
    logic [31:0]            imm;
    logic                   out_valid;
    logic                   out_ready;
    logic [PW-1:0]          sr1_p;
    logic [PW-1:0]          sr2_p;
    logic [PW-1:0]          dr_p;
    logic [PW-1:0]          old_dr_p;
    logic                   dr_alloc;
    logic [31:0]            imm_o;
    logic                   stall;
    logic [RETIRE_W-1:0]    retire_valid;
    logic [RETIRE_W*AW-1:0] retire_areg;
    logic [RETIRE_W*PW-1:0] retire_new_preg;
    logic [RETIRE_W*PW-1:0] retire_old_preg;
    logic                   flush;
    logic [PW:0]            free_count;

    modport master (
        output in_valid, sr1, sr2, dr, dr_we, has_imm, imm, out_ready,
               retire_valid, retire_areg, retire_new_preg, retire_old_preg, flush,
        input  in_ready, out_valid, sr1_p, sr2_p, dr_p, old_dr_p, dr_alloc,
               imm_o, stall, free_count
    );

    modport slave (
        input  in_valid, sr1, sr2, dr, dr_we, has_imm, imm, out_ready,
               retire_valid, retire_areg, retire_new_preg, retire_old_preg, flush,
        output in_ready, out_valid, sr1_p, sr2_p, dr_p, old_dr_p, dr_alloc,
               imm_o, stall, free_count
    );

endinterface

// File: rtl/rename_unit_preg_free_list.sv
// Speculative and committed physical-register free bitmaps with a
// lowest-index allocator, per-lane retire frees and single-cycle flush restore.
module preg_free_list
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int RETIRE_W  = 2,
    localparam int PW = phys_w(PHYS_REGS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   alloc_en,
    output logic [PW-1:0]          alloc_preg,
    input  logic [RETIRE_W-1:0]    retire_valid,
    input  logic [RETIRE_W*PW-1:0] retire_new_preg,
    input  logic [RETIRE_W*PW-1:0] retire_old_preg,
    input  logic                   flush,
    output logic [PW:0]            free_count
);

    logic [PHYS_REGS-1:0] spec_free_q;
    logic [PHYS_REGS-1:0] spec_free_nxt;
    logic [PHYS_REGS-1:0] cmt_free_q;
    logic [PHYS_REGS-1:0] cmt_free_nxt;
    logic [PW:0]          free_cnt_q;
    logic [PW:0]          free_cnt_nxt;

    function automatic logic [PHYS_REGS-1:0] reset_free();
        logic [PHYS_REGS-1:0] r;
        for (int i = 0; i < PHYS_REGS; i++)
            r[i] = (i >= ARCH_REGS);
        return r;
    endfunction

    assign alloc_preg = PW'(lowest_set(MAX_PREGS'(spec_free_q)));
    assign free_count = free_cnt_q;

    // Lanes apply in order so a later lane's clear wins over an earlier set.
    always_comb begin
        spec_free_nxt = spec_free_q;
        cmt_free_nxt  = cmt_free_q;
        if (alloc_en) spec_free_nxt[alloc_preg] = 1'b0;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (retire_valid[k]) begin
                spec_free_nxt[retire_old_preg[k*PW +: PW]] = 1'b1;
                cmt_free_nxt[retire_old_preg[k*PW +: PW]]  = 1'b1;
                cmt_free_nxt[retire_new_preg[k*PW +: PW]]  = 1'b0;
            end
        end
        if (flush) spec_free_nxt = cmt_free_nxt;
        spec_free_nxt[0] = 1'b0;
        cmt_free_nxt[0]  = 1'b0;
        free_cnt_nxt = '0;
        for (int i = 0; i < PHYS_REGS; i++)
            free_cnt_nxt = free_cnt_nxt + (PW+1)'(spec_free_nxt[i]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spec_free_q <= reset_free();
            cmt_free_q  <= reset_free();
            free_cnt_q  <= (PW+1)'(PHYS_REGS - ARCH_REGS);
        end else begin
            spec_free_q <= spec_free_nxt;
            cmt_free_q  <= cmt_free_nxt;
            free_cnt_q  <= free_cnt_nxt;
        end
    end

endmodule

// File: rtl/rename_unit.sv
// Register rename stage: speculative/committed RATs, one rename per cycle
// into a registered output slot, retire-driven commit and flush restore.
module rename_unit
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int RETIRE_W  = 2
) (
    input logic          clk,
    input logic          rstn,
    rename_unit_if.slave rn
);

    localparam int AW = arch_w(ARCH_REGS);
    localparam int PW = phys_w(PHYS_REGS);

    logic [PW-1:0] spec_rat_q  [ARCH_REGS];
    logic [PW-1:0] cmt_rat_q   [ARCH_REGS];
    logic [PW-1:0] cmt_rat_nxt [ARCH_REGS];

    logic          need_alloc;
    logic          in_ready;
    logic          fire;
    logic          alloc_en;
    logic [PW-1:0] alloc_preg;
    logic [PW:0]   free_count;

    logic          vld_p1;
    logic [PW-1:0] sr1_preg_p1;
    logic [PW-1:0] sr2_preg_p1;
    logic [PW-1:0] dr_preg_p1;
    logic [PW-1:0] old_preg_p1;
    logic          alloc_p1;
    logic [31:0]   imm_p1;

    preg_free_list #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS),
        .RETIRE_W  (RETIRE_W)
    ) u_free_list (
        .clk             (clk),
        .rstn            (rstn),
        .alloc_en        (alloc_en),
        .alloc_preg      (alloc_preg),
        .retire_valid    (rn.retire_valid),
        .retire_new_preg (rn.retire_new_preg),
        .retire_old_preg (rn.retire_old_preg),
        .flush           (rn.flush),
        .free_count      (free_count)
    );

    assign need_alloc = rn.dr_we & (rn.dr != '0);
    assign in_ready   = ~rn.flush & (~vld_p1 | rn.out_ready) & ((free_count != '0) | ~need_alloc);
    assign fire       = rn.in_valid & in_ready;
    assign alloc_en   = fire & need_alloc;

    // Retire lanes in order; x0 keeps its hard-wired mapping.
    always_comb begin
        cmt_rat_nxt = cmt_rat_q;
        for (int k = 0; k < RETIRE_W; k++)
            if (rn.retire_valid[k] && (rn.retire_areg[k*AW +: AW] != '0))
                cmt_rat_nxt[rn.retire_areg[k*AW +: AW]] = rn.retire_new_preg[k*PW +: PW];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                spec_rat_q[a] <= PW'(reset_map(a));
                cmt_rat_q[a]  <= PW'(reset_map(a));
            end
        end else begin
            cmt_rat_q <= cmt_rat_nxt;
            if (rn.flush)
                spec_rat_q <= cmt_rat_nxt;
            else if (alloc_en)
                spec_rat_q[rn.dr] <= alloc_preg;
        end
    end

    // ---- rename output stage (p1) ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1      <= 1'b0;
            sr1_preg_p1 <= '0;
            sr2_preg_p1 <= '0;
            dr_preg_p1  <= '0;
            old_preg_p1 <= '0;
            alloc_p1    <= 1'b0;
            imm_p1      <= '0;
        end else begin
            if (rn.flush)
                vld_p1 <= 1'b0;
            else if (fire)
                vld_p1 <= 1'b1;
            else if (rn.out_ready)
                vld_p1 <= 1'b0;
            if (fire) begin
                sr1_preg_p1 <= spec_rat_q[rn.sr1];
                sr2_preg_p1 <= rn.has_imm ? '0 : spec_rat_q[rn.sr2];
                old_preg_p1 <= spec_rat_q[rn.dr];
                dr_preg_p1  <= need_alloc ? alloc_preg : spec_rat_q[rn.dr];
                alloc_p1    <= need_alloc;
                imm_p1      <= rn.imm;
            end
        end
    end

    assign rn.in_ready   = in_ready;
    assign rn.stall      = rn.in_valid & ~in_ready;
    assign rn.out_valid  = vld_p1;
    assign rn.sr1_p      = sr1_preg_p1;
    assign rn.sr2_p      = sr2_preg_p1;
    assign rn.dr_p       = dr_preg_p1;
    assign rn.old_dr_p   = old_preg_p1;
    assign rn.dr_alloc   = alloc_p1;
    assign rn.imm_o      = imm_p1;
    assign rn.free_count = free_count;

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: vector table with a scoreboard of renamed outputs,
// plus hand-written exhaustion, retire-reuse and output-hold sequences.
module tb_rename_unit;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int RETIRE_W  = 2;
    localparam int NV        = 14;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    rename_unit_if #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .RETIRE_W(RETIRE_W)) rif ();

    rename_unit #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .RETIRE_W(RETIRE_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rn   (rif)
    );

    typedef struct {
        logic [5:0]  sr1_p;
        logic [5:0]  sr2_p;
        logic [5:0]  dr_p;
        logic [5:0]  old_dr_p;
        logic        dr_alloc;
        logic [31:0] imm;
    } out_t;

    typedef struct {
        logic        in_valid;
        logic        flush;
        logic [4:0]  sr1;
        logic [4:0]  sr2;
        logic [4:0]  dr;
        logic        dr_we;
        logic        has_imm;
        logic [31:0] imm;
        logic [1:0]  rv;
        logic [4:0]  ra0;
        logic [5:0]  rn0;
        logic [5:0]  ro0;
        logic [4:0]  ra1;
        logic [5:0]  rn1;
        logic [5:0]  ro1;
        logic        exp_ready;
        logic        exp_ovalid;
        out_t        exp;
        logic [6:0]  exp_fc;
    } vec_t;

    out_t        sb[$];
    vec_t        tbl[NV];
    logic [63:0] cfree;
    logic [63:0] cfree_nxt;

    // Shadow committed free set, used only to flag illegal retire stimulus.
    always_comb begin
        cfree_nxt = cfree;
        for (int k = 0; k < RETIRE_W; k++)
            if (rif.retire_valid[k]) begin
                cfree_nxt[rif.retire_old_preg[k*6 +: 6]] = 1'b1;
                cfree_nxt[rif.retire_new_preg[k*6 +: 6]] = 1'b0;
            end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn)
            cfree <= {{32{1'b1}}, {32{1'b0}}};
        else begin
            for (int k = 0; k < RETIRE_W; k++)
                if (rif.retire_valid[k])
                    assert (!cfree[rif.retire_old_preg[k*6 +: 6]])
                        else $error("retire of a preg that is already free");
            cfree <= cfree_nxt;
        end
    end

    function automatic out_t mko(input int s1p, input int s2p, input int dp, input int op,
                                 input int al, input int im);
        out_t o;
        o.sr1_p    = 6'(s1p);
        o.sr2_p    = 6'(s2p);
        o.dr_p     = 6'(dp);
        o.old_dr_p = 6'(op);
        o.dr_alloc = 1'(al);
        o.imm      = 32'(im);
        return o;
    endfunction

    function automatic vec_t mk(input int iv, input int fl, input int s1, input int s2, input int d,
                                input int we, input int hi, input int im, input int er, input int eov,
                                input int e1, input int e2, input int ed, input int eo, input int ea,
                                input int efc);
        vec_t v;
        v.in_valid = 1'(iv);  v.flush   = 1'(fl);
        v.sr1 = 5'(s1);       v.sr2 = 5'(s2);       v.dr = 5'(d);
        v.dr_we = 1'(we);     v.has_imm = 1'(hi);   v.imm = 32'(im);
        v.rv = '0;  v.ra0 = '0;  v.rn0 = '0;  v.ro0 = '0;  v.ra1 = '0;  v.rn1 = '0;  v.ro1 = '0;
        v.exp_ready = 1'(er); v.exp_ovalid = 1'(eov);
        v.exp    = mko(e1, e2, ed, eo, ea, im);
        v.exp_fc = 7'(efc);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic cmp_out(input out_t e);
        check("sr1_p",    32'(rif.sr1_p),    32'(e.sr1_p));
        check("sr2_p",    32'(rif.sr2_p),    32'(e.sr2_p));
        check("dr_p",     32'(rif.dr_p),     32'(e.dr_p));
        check("old_dr_p", 32'(rif.old_dr_p), 32'(e.old_dr_p));
        check("dr_alloc", 32'(rif.dr_alloc), 32'(e.dr_alloc));
        check("imm_o",    rif.imm_o,         e.imm);
    endtask

    task automatic pop_cmp();
        out_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard: unexpected output dr_p=%0d, want no output", rif.dr_p);
        end else begin
            e = sb.pop_front();
            cmp_out(e);
        end
    endtask

    task automatic idle();
        rif.in_valid = 1'b0;  rif.flush = 1'b0;  rif.out_ready = 1'b1;
        rif.sr1 = '0;  rif.sr2 = '0;  rif.dr = '0;  rif.dr_we = 1'b0;  rif.has_imm = 1'b0;
        rif.imm = '0;  rif.retire_valid = '0;  rif.retire_areg = '0;
        rif.retire_new_preg = '0;  rif.retire_old_preg = '0;
    endtask

    task automatic drive(input vec_t v);
        rif.in_valid = v.in_valid;  rif.flush = v.flush;  rif.out_ready = 1'b1;
        rif.sr1 = v.sr1;  rif.sr2 = v.sr2;  rif.dr = v.dr;
        rif.dr_we = v.dr_we;  rif.has_imm = v.has_imm;  rif.imm = v.imm;
        rif.retire_valid    = v.rv;
        rif.retire_areg     = {v.ra1, v.ra0};
        rif.retire_new_preg = {v.rn1, v.rn0};
        rif.retire_old_preg = {v.ro1, v.ro0};
    endtask

    task automatic set_rename(input int s1, input int s2, input int d, input int im);
        rif.in_valid = 1'b1;  rif.sr1 = 5'(s1);  rif.sr2 = 5'(s2);  rif.dr = 5'(d);
        rif.dr_we = 1'b1;  rif.has_imm = 1'b0;  rif.imm = 32'(im);
    endtask

    task automatic async_reset_check(input string tag);
        #2 rstn = 1'b0;
        idle();
        #1;
        check({tag, " out_valid"},  32'(rif.out_valid),  32'd0);
        check({tag, " dr_p"},       32'(rif.dr_p),       32'd0);
        check({tag, " imm_o"},      rif.imm_o,           32'd0);
        check({tag, " free_count"}, 32'(rif.free_count), 32'd32);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 1, 2, 5, 1, 0, 'h100,  1, 1,  1,  2, 32,  5, 1, 31);
        tbl[1]  = mk(1, 0, 5, 5, 5, 1, 0, 'h101,  1, 1, 32, 32, 33, 32, 1, 30);
        tbl[2]  = mk(1, 0, 5, 5, 5, 1, 0, 'h102,  1, 1, 33, 33, 34, 33, 1, 29);
        tbl[3]  = mk(1, 0, 5, 3, 5, 0, 0, 'h103,  1, 1, 34,  3, 34, 34, 0, 29);
        tbl[4]  = mk(1, 0, 7, 9, 0, 1, 1, 'h1234, 1, 1,  7,  0,  0,  0, 0, 29);
        tbl[5]  = mk(1, 0, 5, 8, 6, 1, 1, 'h105,  1, 1, 34,  0, 35,  6, 1, 28);
        tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 0,      0, 0,  0,  0,  0,  0, 0, 32);
        tbl[7]  = mk(1, 0, 1, 2, 3, 1, 0, 'h107,  1, 1,  1,  2, 32,  3, 1, 31);
        tbl[8]  = mk(1, 0, 3, 3, 4, 1, 0, 'h108,  1, 1, 32, 32, 33,  4, 1, 30);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0,      0, 0,  0,  0,  0,  0, 0, 32);
        tbl[9].rv = 2'b01;  tbl[9].ra0 = 5'd3;  tbl[9].rn0 = 6'd32;  tbl[9].ro0 = 6'd3;
        tbl[10] = mk(1, 0, 3, 4, 3, 1, 0, 'h10a,  1, 1, 32,  4,  3, 32, 1, 31);
        tbl[11] = mk(1, 0, 4, 0, 4, 1, 0, 'h10b,  1, 1,  4,  0, 33,  4, 1, 30);
        tbl[12] = mk(1, 0, 1, 1, 7, 1, 0, 'h10c,  1, 1,  1,  1, 34,  7, 1, 31);
        tbl[12].rv = 2'b11;
        tbl[12].ra0 = 5'd3;  tbl[12].rn0 = 6'd3;   tbl[12].ro0 = 6'd32;
        tbl[12].ra1 = 5'd4;  tbl[12].rn1 = 6'd33;  tbl[12].ro1 = 6'd4;
        tbl[13] = mk(1, 0, 1, 1, 8, 1, 0, 'h10d,  1, 1,  1,  1,  4,  8, 1, 30);

        idle();
        #2 rstn = 1'b0;
        #1;
        check("reset out_valid",  32'(rif.out_valid),  32'd0);
        check("reset sr1_p",      32'(rif.sr1_p),      32'd0);
        check("reset dr_p",       32'(rif.dr_p),       32'd0);
        check("reset old_dr_p",   32'(rif.old_dr_p),   32'd0);
        check("reset dr_alloc",   32'(rif.dr_alloc),   32'd0);
        check("reset imm_o",      rif.imm_o,           32'd0);
        check("reset free_count", 32'(rif.free_count), 32'd32);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("row%0d in_ready", i), 32'(rif.in_ready), 32'(tbl[i].exp_ready));
            check($sformatf("row%0d stall", i),    32'(rif.stall),
                  32'(tbl[i].in_valid & ~tbl[i].exp_ready));
            if (tbl[i].in_valid && tbl[i].exp_ready) sb.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("row%0d out_valid", i),  32'(rif.out_valid),  32'(tbl[i].exp_ovalid));
            check($sformatf("row%0d free_count", i), 32'(rif.free_count), 32'(tbl[i].exp_fc));
            if (rif.out_valid) pop_cmp();
        end
        check("table drained", 32'(sb.size()), 32'd0);
        async_reset_check("midrst1");

        // Exhaust the free list with x1 = x1 + x1.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            set_rename(1, 1, 1, i);
            #1;
            check("exhaust in_ready", 32'(rif.in_ready), 32'd1);
            sb.push_back(mko((i == 0) ? 1 : 31 + i, (i == 0) ? 1 : 31 + i, 32 + i,
                             (i == 0) ? 1 : 31 + i, 1, i));
            @(posedge clk);
            #1;
            if (rif.out_valid) pop_cmp();
            else check("exhaust out_valid", 32'(rif.out_valid), 32'd1);
        end
        check("empty free_count", 32'(rif.free_count), 32'd0);

        @(negedge clk);
        set_rename(1, 1, 1, 'h77);
        rif.retire_valid    = 2'b01;
        rif.retire_areg     = {5'd0, 5'd5};
        rif.retire_new_preg = {6'd0, 6'd40};
        rif.retire_old_preg = {6'd0, 6'd5};
        #1;
        check("full in_ready", 32'(rif.in_ready), 32'd0);
        check("full stall",    32'(rif.stall),    32'd1);
        rif.dr_we = 1'b0;
        #1;
        check("full store in_ready", 32'(rif.in_ready), 32'd1);
        rif.dr_we = 1'b1;
        #1;
        check("full retire-cycle in_ready", 32'(rif.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("retire out_valid",  32'(rif.out_valid),  32'd0);
        check("retire free_count", 32'(rif.free_count), 32'd1);
        @(negedge clk);
        rif.retire_valid = '0;
        #1;
        check("reuse in_ready", 32'(rif.in_ready), 32'd1);
        sb.push_back(mko(63, 63, 5, 63, 1, 'h77));
        @(posedge clk);
        #1;
        check("reuse out_valid", 32'(rif.out_valid), 32'd1);
        if (rif.out_valid) pop_cmp();
        check("reuse free_count", 32'(rif.free_count), 32'd0);
        async_reset_check("midrst2");

        // Downstream back-pressure holds the output slot.
        @(negedge clk);
        set_rename(1, 1, 2, 'haa);
        rif.out_ready = 1'b0;
        #1;
        check("hold first in_ready", 32'(rif.in_ready), 32'd1);
        sb.push_back(mko(1, 1, 32, 2, 1, 'haa));
        @(posedge clk);
        #1;
        check("hold first out_valid", 32'(rif.out_valid), 32'd1);
        cmp_out(sb[0]);
        @(negedge clk);
        set_rename(2, 2, 3, 'hbb);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold in_ready", 32'(rif.in_ready), 32'd0);
            check("hold stall",    32'(rif.stall),    32'd1);
            @(posedge clk);
            #1;
            check("hold out_valid",  32'(rif.out_valid),  32'd1);
            check("hold free_count", 32'(rif.free_count), 32'd31);
            cmp_out(sb[0]);
            @(negedge clk);
        end
        rif.out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(rif.in_ready), 32'd1);
        sb.push_back(mko(32, 32, 33, 3, 1, 'hbb));
        @(posedge clk);
        #1;
        void'(sb.pop_front());
        check("release out_valid",  32'(rif.out_valid),  32'd1);
        check("release free_count", 32'(rif.free_count), 32'd30);
        if (rif.out_valid) pop_cmp();
        idle();
        @(posedge clk);
        #1;
        check("drain out_valid", 32'(rif.out_valid), 32'd0);
        check("final drained",   32'(sb.size()),     32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
